// File: rtl/counter_multimode_generic_pkg.sv
// Shared encodings for the multimode counter: boundary modes and FSM states.
package counter_multimode_generic_pkg;

  localparam int unsigned CNT_MODE_W  = 2;
  localparam int unsigned CNT_STATE_W = 1;

  localparam logic [CNT_MODE_W-1:0] CNT_MODE_WRAP    = 2'b00;
  localparam logic [CNT_MODE_W-1:0] CNT_MODE_SAT     = 2'b01;
  localparam logic [CNT_MODE_W-1:0] CNT_MODE_ONESHOT = 2'b10;

  localparam logic [CNT_STATE_W-1:0] CNT_ARMED  = 1'b0;
  localparam logic [CNT_STATE_W-1:0] CNT_HALTED = 1'b1;

endpackage : counter_multimode_generic_pkg

// File: rtl/counter_multimode_generic_if.sv
// Control/status bundle for the multimode counter; master drives controls, slave is the counter.
interface counter_multimode_generic_if #(
  parameter int unsigned SIZE = 16
);
  import counter_multimode_generic_pkg::*;

  logic                  enable;
  logic                  down;
  logic [CNT_MODE_W-1:0] mode;
  logic                  load;
  logic [SIZE-1:0]       load_value;
  logic                  clear_flags;
  logic [SIZE-1:0]       q;
  logic                  terminal_count;
  logic                  overflow;
  logic                  done;

  modport master (
    output enable, down, mode, load, load_value, clear_flags,
    input  q, terminal_count, overflow, done
  );

  modport slave (
    input  enable, down, mode, load, load_value, clear_flags,
    output q, terminal_count, overflow, done
  );

endinterface : counter_multimode_generic_if

// File: rtl/counter_multimode_generic_next_value.sv
// Combinational step: next count and boundary detection for one enabled step.
module counter_next_value
  import counter_multimode_generic_pkg::*;
#(
  parameter int unsigned    SIZE = 16,
  parameter logic [SIZE-1:0] MAX = '1
) (
  input  logic [SIZE-1:0]       q_i,
  input  logic                  down_i,
  input  logic [CNT_MODE_W-1:0] mode_i,
  output logic [SIZE-1:0]       q_next_o,
  output logic                  boundary_o
);

  always_comb begin
    boundary_o = down_i ? (q_i == '0) : (q_i == MAX);
    q_next_o   = down_i ? (q_i - SIZE'(1)) : (q_i + SIZE'(1));
    if (boundary_o) begin
      unique case (mode_i)
        CNT_MODE_SAT,
        CNT_MODE_ONESHOT: q_next_o = q_i;
        // Wrap; the reserved encoding falls back to wrap as well.
        default:          q_next_o = down_i ? MAX : '0;
      endcase
    end
  end

endmodule : counter_next_value

// File: rtl/counter_multimode_generic.sv
// Up/down counter with programmable limit, clamped load, wrap/saturate/one-shot
// boundary modes, terminal-count pulse and sticky overflow.
module counter_multimode_generic
  import counter_multimode_generic_pkg::*;
#(
  parameter int unsigned     SIZE        = 16,
  parameter logic [SIZE-1:0] MAX         = '1,
  parameter logic [SIZE-1:0] RESET_VALUE = '0
) (
  input logic                        clk_i,
  input logic                        rst_ni,
  counter_multimode_generic_if.slave bus
);

  logic [SIZE-1:0]        q_q, q_d;
  logic                   tc_q, tc_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;
  logic [CNT_STATE_W-1:0] state_q, state_d;
  logic [SIZE-1:0]        step_q;
  logic                   boundary;
  logic [SIZE-1:0]        load_clamped;

  counter_next_value #(
    .SIZE (SIZE),
    .MAX  (MAX)
  ) u_next (
    .q_i        (q_q),
    .down_i     (bus.down),
    .mode_i     (bus.mode),
    .q_next_o   (step_q),
    .boundary_o (boundary)
  );

  assign load_clamped = (bus.load_value > MAX) ? MAX : bus.load_value;

  // Next state: load beats stepping; a boundary event beats ClearFlags.
  always_comb begin
    q_d     = q_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~bus.clear_flags;
    state_d = state_q;
    if (bus.load) begin
      q_d     = load_clamped;
      ovf_d   = 1'b0;
      state_d = CNT_ARMED;
    end else begin
      unique case (state_q)
        CNT_ARMED: begin
          if (bus.enable) begin
            q_d = step_q;
            if (boundary) begin
              tc_d  = 1'b1;
              ovf_d = 1'b1;
              if (bus.mode == CNT_MODE_ONESHOT) state_d = CNT_HALTED;
            end
          end
        end
        CNT_HALTED: begin
          if (bus.mode != CNT_MODE_ONESHOT) state_d = CNT_ARMED;
        end
        default: state_d = CNT_ARMED;
      endcase
    end
    done_d = (state_d == CNT_HALTED);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q     <= RESET_VALUE;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      state_q <= CNT_ARMED;
    end else begin
      q_q     <= q_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

  assign bus.q              = q_q;
  assign bus.terminal_count = tc_q;
  assign bus.overflow       = ovf_q;
  assign bus.done           = done_q;

endmodule : counter_multimode_generic

// File: tb/tb_counter_multimode_generic.sv
// Scoreboarded bench for counter_multimode_generic with SIZE=4, MAX=9, RESET_VALUE=2.
module tb_counter_multimode_generic;

  localparam int unsigned SIZE = 4;
  localparam int          MAXV = 9;
  localparam int          RV   = 2;

  typedef struct {
    int    q;
    bit    tc;
    bit    ovf;
    bit    done;
    string name;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];

  int n_tests;
  int n_fail;

  int m_q;
  bit m_tc, m_ovf, m_halt;

  counter_multimode_generic_if #(.SIZE(SIZE)) bus ();

  counter_multimode_generic #(
    .SIZE        (SIZE),
    .MAX         (4'd9),
    .RESET_VALUE (4'd2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference of one clock edge, written from the operation rules.
  task automatic model_edge(input bit rst, input bit en, input bit dn, input bit [1:0] md,
                            input bit ld, input int lv, input bit clr);
    bit bnd;
    if (!rst) begin
      m_q = RV; m_tc = 0; m_ovf = 0; m_halt = 0;
    end else if (ld) begin
      m_q = (lv > MAXV) ? MAXV : lv; m_tc = 0; m_ovf = 0; m_halt = 0;
    end else begin
      m_tc = 0;
      if (clr) m_ovf = 0;
      if (m_halt) begin
        if (md != 2'b10) m_halt = 0;
      end else if (en) begin
        bnd = dn ? (m_q == 0) : (m_q == MAXV);
        if (bnd) begin
          m_tc = 1; m_ovf = 1;
          if (md == 2'b10) m_halt = 1;
          else if (md != 2'b01) m_q = dn ? MAXV : 0;
        end else begin
          m_q = dn ? m_q - 1 : m_q + 1;
        end
      end
    end
  endtask

  // Drive one cycle at the falling edge, push the model's result, then compare one edge later.
  task automatic cycle(input bit rst, input bit en, input bit dn, input bit [1:0] md,
                       input bit ld, input int lv, input bit clr, input string name);
    exp_t e;
    rst_n           = rst;
    bus.enable      = en;
    bus.down        = dn;
    bus.mode        = md;
    bus.load        = ld;
    bus.load_value  = SIZE'(lv);
    bus.clear_flags = clr;
    model_edge(rst, en, dn, md, ld, lv, clr);
    e.q = m_q; e.tc = m_tc; e.ovf = m_ovf; e.done = m_halt; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    if (int'(bus.q) !== e.q) begin
      n_fail++;
      $display("FAIL %s q: got %0d expected %0d", e.name, bus.q, e.q);
    end
    n_tests++;
    if (bus.terminal_count !== e.tc) begin
      n_fail++;
      $display("FAIL %s tc: got %b expected %b", e.name, bus.terminal_count, e.tc);
    end
    n_tests++;
    if (bus.overflow !== e.ovf) begin
      n_fail++;
      $display("FAIL %s ovf: got %b expected %b", e.name, bus.overflow, e.ovf);
    end
    n_tests++;
    if (bus.done !== e.done) begin
      n_fail++;
      $display("FAIL %s done: got %b expected %b", e.name, bus.done, e.done);
    end
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 2'b00, 0, 0, 0, "reset0");
    cycle(0, 1, 0, 2'b00, 1, 7, 0, "reset1");
    n_tests++;
    if (bus.q !== 4'd2) begin
      n_fail++;
      $display("FAIL reset_value q: got %0d expected 2", bus.q);
    end
  endtask

  task automatic test_wrap();
    cycle(1, 0, 0, 2'b00, 1, 0, 0, "wrap_load0");
    for (int i = 1; i <= 10; i++) cycle(1, 1, 0, 2'b00, 0, 0, 0, $sformatf("wrap_step%0d", i));
    n_tests++;
    if (bus.q !== 4'd0 || bus.terminal_count !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_to_zero: got q=%0d tc=%b expected q=0 tc=1", bus.q, bus.terminal_count);
    end
    cycle(1, 1, 0, 2'b00, 0, 0, 0, "wrap_after");
  endtask

  task automatic test_down();
    cycle(1, 0, 1, 2'b00, 1, 0, 0, "down_load0");
    cycle(1, 1, 1, 2'b00, 0, 0, 0, "down_wrap");
    n_tests++;
    if (bus.q !== 4'd9) begin
      n_fail++;
      $display("FAIL down_wrap_max q: got %0d expected 9", bus.q);
    end
    cycle(1, 0, 1, 2'b01, 1, 0, 0, "sat_load0");
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 2'b01, 0, 0, 0, $sformatf("sat_hold%0d", i));
    n_tests++;
    if (bus.q !== 4'd0 || bus.terminal_count !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_hold: got q=%0d tc=%b expected q=0 tc=1", bus.q, bus.terminal_count);
    end
  endtask

  task automatic test_oneshot();
    cycle(1, 0, 0, 2'b10, 1, 7, 0, "os_load7");
    cycle(1, 1, 0, 2'b10, 0, 0, 0, "os_8");
    cycle(1, 1, 0, 2'b10, 0, 0, 0, "os_9");
    cycle(1, 1, 0, 2'b10, 0, 0, 0, "os_event");
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 2'b10, 0, 0, 0, $sformatf("os_frozen%0d", i));
    n_tests++;
    if (bus.q !== 4'd9 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL os_halted: got q=%0d done=%b expected q=9 done=1", bus.q, bus.done);
    end
    cycle(1, 1, 0, 2'b10, 1, 3, 0, "os_reload3");
    cycle(1, 1, 0, 2'b10, 0, 0, 0, "os_resume");
    n_tests++;
    if (bus.q !== 4'd4 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL os_resume: got q=%0d done=%b expected q=4 done=0", bus.q, bus.done);
    end
    cycle(1, 1, 0, 2'b10, 0, 0, 0, "os_5");
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 2'b10, 0, 0, 0, $sformatf("os_run%0d", i));
    cycle(1, 0, 0, 2'b00, 0, 0, 0, "os_exit_mode");
    cycle(1, 1, 0, 2'b00, 0, 0, 0, "os_after_exit");
  endtask

  task automatic test_load_clamp();
    cycle(1, 1, 0, 2'b00, 1, 15, 0, "clamp_load15");
    n_tests++;
    if (bus.q !== 4'd9 || bus.terminal_count !== 1'b0) begin
      n_fail++;
      $display("FAIL clamp: got q=%0d tc=%b expected q=9 tc=0", bus.q, bus.terminal_count);
    end
    cycle(1, 1, 0, 2'b00, 0, 0, 0, "clamp_wrap");
  endtask

  task automatic test_flags();
    cycle(1, 0, 0, 2'b00, 1, 9, 0, "flags_load9");
    cycle(1, 1, 0, 2'b00, 0, 0, 1, "flags_event_and_clear");
    n_tests++;
    if (bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL flags_set_wins: got ovf=%b expected 1", bus.overflow);
    end
    cycle(1, 0, 0, 2'b00, 0, 0, 1, "flags_clear");
    n_tests++;
    if (bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL flags_clear: got ovf=%b expected 0", bus.overflow);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 0, 2'b00, 1, 9, 0, "rm_load9");
    cycle(1, 1, 0, 2'b00, 0, 0, 0, "rm_event");
    cycle(1, 0, 0, 2'b00, 1, 5, 0, "rm_load5");
    cycle(0, 1, 0, 2'b00, 1, 8, 0, "rm_reset");
    cycle(1, 0, 0, 2'b00, 0, 0, 0, "rm_idle");
    cycle(1, 1, 0, 2'b00, 0, 0, 0, "rm_first_step");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      bit ld;
      ld = ($urandom_range(0, 15) == 0);
      cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), ld, int'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.down = 1'b0; bus.mode = 2'b00;
    bus.load = 1'b0; bus.load_value = '0; bus.clear_flags = 1'b0;
    m_q = RV; m_tc = 0; m_ovf = 0; m_halt = 0;
    @(negedge clk);
    test_reset();
    test_wrap();
    test_down();
    test_oneshot();
    test_load_clamp();
    test_flags();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_counter_multimode_generic

// File: doc/counter_multimode_generic.md
# counter_multimode_generic

Parametrised up/down counter that generalises the fixed-width up-counters with a programmable upper limit, synchronous parallel load, and three boundary modes: wrap, saturate and one-shot. It is the common counting primitive for the control path: instruction/address sequencing, iteration loops and timeouts. It also reports boundary events through a one-cycle terminal-count pulse and a sticky overflow flag.

## Interface
Parameters:
- SIZE, 16, counter width in bits (≥2).
- MAX, {SIZE{1'b1}}, inclusive upper limit; count range is 0..MAX.
- RESET_VALUE, 0, value of Q after reset (must be ≤ MAX).

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset (sampled on rising Clock; 0 = reset).
- Enable  in  1  apply one count step this cycle.
- Down  in  1  step direction: 0 = +1, 1 = −1.
- Mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap).
- Load  in  1  synchronous parallel load.
- LoadValue  in  SIZE  value to load; values above MAX are clamped to MAX.
- ClearFlags  in  1  clears Overflow.
- Q  out  SIZE  current count (registered).
- TerminalCount  out  1  one-cycle registered pulse on a boundary event.
- Overflow  out  1  sticky boundary-event flag.
- Done  out  1  one-shot halted (state HALTED).

## Operation
- Priority per edge: Reset > Load > Enable step.
- Reset (Reset=0): Q=RESET_VALUE, TerminalCount=0, Overflow=0, state=ARMED, Done=0.
- Load: Q=min(LoadValue, MAX), state=ARMED, Overflow cleared, TerminalCount=0. Enable is ignored that cycle.
- Boundary condition: Up at Q==MAX, or Down at Q==0.
- Step with no boundary: Q=Q±1.
- Step at a boundary (boundary event), by Mode:
  - wrap: Q→0 (up) or MAX (down).
  - saturate: Q holds.
  - one-shot: Q holds and state→HALTED.
- Every boundary event sets TerminalCount=1 for the next cycle and sets Overflow. If a boundary event and ClearFlags occur in the same cycle, the set wins.
- FSM states:
  - ARMED: counting permitted.
  - HALTED: Enable is ignored and Q is frozen.
  - Exits from HALTED: Load → ARMED; Mode ≠ one-shot → ARMED on the next edge (no Q change).
- Arithmetic is SIZE bits with no carry-out port. The MAX comparison is exact equality. Q never exceeds MAX.
- Mode and Down are sampled each edge; changing them mid-count takes effect on that edge.

## Timing
- All outputs are registered. Q updates on the edge where Enable/Load is sampled (latency 1).
- TerminalCount is high exactly for the cycle after the event edge, i.e. coincident with the wrapped/held Q. Back-to-back events (saturate with Enable held) give a continuously high TerminalCount.
- Overflow rises with TerminalCount. It falls on the edge after ClearFlags=1 (or on Load/Reset).
- Done rises on the event edge in one-shot mode. It falls on the Load edge.
- Reset asserted mid-count overrides Load/Enable on that edge. The first count after deassertion happens on the next edge with Enable=1.

## Structure
- Shared package (aDefinitions): mode encodings CNT_MODE_WRAP=2'b00, CNT_MODE_SAT=2'b01, CNT_MODE_ONESHOT=2'b10; FSM state encodings CNT_ARMED/CNT_HALTED.
- One combinational sub-module, counter_next_value: inputs Q, Down, Mode, MAX (parameter); outputs next Q and the boundary flag. The top level holds registers, FSM, flags and load clamping.

## Test plan
- Wrap: SIZE=4, MAX=9, Mode=00, Enable=1, Down=0 from 0 → Q sequence 0..9,0. TerminalCount high only in the cycle Q returns to 0. Overflow stays 1.
- Down wrap/saturate: Load 0, Down=1, Mode=00 → Q=9 next cycle with TerminalCount. Repeat with Mode=01 → Q stays 0 and TerminalCount stays high while Enable is held.
- One-shot: Load 7, Mode=10, up → Q 8, 9, then HALTED with Done=1 and Q frozen at 9 for 5 further Enable cycles. Load 3 → Done=0, Q=3, counting resumes.
- Load priority/clamp: Load=1, Enable=1, LoadValue=15 with MAX=9 → Q=9 with no step and TerminalCount=0. Next Enable step up (wrap) → Q=0 and TerminalCount=1.
- Flags: a boundary event and ClearFlags in the same cycle → Overflow=1. ClearFlags alone next cycle → Overflow=0.
- Reset mid-operation: Reset=0 for one cycle while Q=5 with Enable=1, Load=1 → Q=RESET_VALUE, all flags 0, Done=0, state ARMED.
